// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage control bundle: hazard/memory handshake, D/M redirect requests,
// and the fetch PC and status flags driven back by the sequencer.
interface pc_fetch_ctrl_if;
  logic        stall;
  logic        imem_ready;
  logic        br_req;
  logic [31:0] br_target;
  logic        j_req;
  logic [31:0] j_target;
  logic        eret_req;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        f_flush;
  logic        f_adel;
  logic        redirect_pending;

  modport master (
    output stall, imem_ready, br_req, br_target, j_req, j_target,
           eret_req, epc, exc_req,
    input  f_pc, f_valid, f_flush, f_adel, redirect_pending
  );

  modport slave (
    input  stall, imem_ready, br_req, br_target, j_req, j_target,
           eret_req, epc, exc_req,
    output f_pc, f_valid, f_flush, f_adel, redirect_pending
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// F-stage PC sequencer: picks next PC among exception, eret, jump, branch,
// a buffered redirect and sequential advance; flags fetch address errors.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFC
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q,       state_d;
  logic [31:0] f_pc_q,        f_pc_d;
  logic        f_valid_q,     f_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        f_flush;
  logic        adv;
  logic [31:0] redir_target;

  function automatic logic fetch_addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_BASE) || (a > IMEM_TOP);
  endfunction

  assign adv          = f_valid_q & ~bus.stall & bus.imem_ready;
  assign redir_target = bus.j_req ? bus.j_target : bus.br_target;

  always_comb begin
    state_d       = state_q;
    f_pc_d        = f_pc_q;
    f_valid_d     = 1'b1;
    pend_target_d = pend_target_q;
    f_flush       = 1'b0;

    if (bus.exc_req) begin
      f_pc_d        = EXC_VEC;
      state_d       = RUN;
      pend_target_d = '0;
      f_flush       = 1'b1;
    end else if (bus.eret_req && !bus.stall) begin
      f_pc_d        = bus.epc;
      state_d       = RUN;
      pend_target_d = '0;
      f_flush       = 1'b1;
    end else if ((bus.j_req || bus.br_req) && !bus.stall) begin
      // D has moved past the branch; if F cannot take it now, remember it.
      if (bus.imem_ready) begin
        f_pc_d  = redir_target;
        state_d = RUN;
      end else begin
        pend_target_d = redir_target;
        state_d       = PEND;
      end
    end else if (adv) begin
      if (state_q == PEND) begin
        f_pc_d  = pend_target_q;
        state_d = RUN;
      end else begin
        f_pc_d = f_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      f_pc_q        <= RESET_VEC;
      f_valid_q     <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      f_pc_q        <= f_pc_d;
      f_valid_q     <= f_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.f_pc             = f_pc_q;
  assign bus.f_valid          = f_valid_q;
  assign bus.f_flush          = f_flush;
  assign bus.f_adel           = f_valid_q & fetch_addr_bad(f_pc_q);
  assign bus.redirect_pending = (state_q == PEND);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, mid-run reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_TOP  = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(
    .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC),
    .IMEM_BASE(IMEM_BASE), .IMEM_TOP(IMEM_TOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        stall;
    logic        rdy;
    logic        br;
    logic [31:0] brt;
    logic        j;
    logic [31:0] jt;
    logic        eret;
    logic [31:0] epc;
    logic        exc;
    logic        exp_flush;
    logic        exp_adel;
    logic [31:0] exp_pc;
    logic        exp_pend;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic stall, logic rdy, logic br, logic [31:0] brt,
                              logic j, logic [31:0] jt, logic eret, logic [31:0] epc,
                              logic exc, logic fl, logic ad, logic [31:0] pc, logic pd);
    vec_t v;
    v.stall = stall; v.rdy = rdy; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
    v.eret = eret; v.epc = epc; v.exc = exc;
    v.exp_flush = fl; v.exp_adel = ad; v.exp_pc = pc; v.exp_pend = pd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic stall, logic rdy, logic br, logic [31:0] brt,
                       logic j, logic [31:0] jt, logic eret, logic [31:0] epc, logic exc);
    bus.stall = stall; bus.imem_ready = rdy;
    bus.br_req = br;   bus.br_target = brt;
    bus.j_req = j;     bus.j_target = jt;
    bus.eret_req = eret; bus.epc = epc;
    bus.exc_req = exc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_pend[$];

  task automatic model_update(logic stall, logic rdy, logic br, logic [31:0] brt,
                              logic j, logic [31:0] jt, logic eret, logic [31:0] epc,
                              logic exc);
    logic [31:0] t;
    if (exc) begin
      m_pc = EXC_VEC; m_pend.delete();
    end else if (eret && !stall) begin
      m_pc = epc; m_pend.delete();
    end else if ((j || br) && !stall) begin
      t = j ? jt : brt;
      m_pend.delete();
      if (rdy) m_pc = t;
      else     m_pend.push_back(t);
    end else if (m_valid && !stall && rdy) begin
      if (m_pend.size() != 0) m_pc = m_pend.pop_front();
      else                    m_pc = m_pc + 32'd4;
    end
    m_valid = 1'b1;
  endtask

  function automatic logic model_adel();
    return m_valid && ((m_pc % 4) != 0 || m_pc < IMEM_BASE || m_pc > IMEM_TOP);
  endfunction

  initial begin
    logic s, r, b, jj, e, x;
    logic [31:0] bt, jt2, ep;

    reset = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc",    bus.f_pc, RESET_VEC);
    check("reset_valid", {31'd0, bus.f_valid}, 0);
    check("reset_pend",  {31'd0, bus.redirect_pending}, 0);
    reset = 1'b1;

    //        st rdy br brt           j  jt            er epc           ex fl ad pc            pd
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3000, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3004, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3008, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_300C, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3010, 0));
    vt.push_back(mk(1,1, 1,32'h3040,    0,0,            0,0,            0, 0,0, 32'h0000_3010, 0));
    vt.push_back(mk(0,1, 1,32'h3040,    0,0,            0,0,            0, 0,0, 32'h0000_3040, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'h3020,     0,0,            0, 0,0, 32'h0000_3020, 0));
    vt.push_back(mk(0,0, 0,0,           1,32'h3100,     0,0,            0, 0,0, 32'h0000_3020, 1));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3100, 0));
    vt.push_back(mk(0,0, 0,0,           1,32'h3100,     0,0,            0, 0,0, 32'h0000_3100, 1));
    vt.push_back(mk(1,0, 0,0,           0,0,            0,0,            1, 1,0, 32'h0000_4180, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            1,32'h3058,     0, 1,0, 32'h0000_3058, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            1,32'h3058,     1, 1,0, 32'h0000_4180, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'h3002,     0,0,            0, 0,0, 32'h0000_3002, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,1, 32'h0000_3006, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'h7000,     0,0,            0, 0,1, 32'h0000_7000, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,1, 32'h0000_7004, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'hFFFF_FFFC,0,0,            0, 0,1, 32'hFFFF_FFFC, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,1, 32'h0000_0000, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,1, 32'h0000_0004, 0));
    vt.push_back(mk(1,1, 0,0,           0,0,            1,32'h3058,     0, 0,1, 32'h0000_0004, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'h3000,     0,0,            0, 0,1, 32'h0000_3000, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3004, 0));
    vt.push_back(mk(0,1, 1,32'h3200,    1,32'h3300,     0,0,            0, 0,0, 32'h0000_3300, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3304, 0));
    vt.push_back(mk(0,0, 1,32'h3400,    0,0,            0,0,            0, 0,0, 32'h0000_3304, 1));
    vt.push_back(mk(0,0, 0,0,           1,32'h3500,     0,0,            0, 0,0, 32'h0000_3304, 1));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3500, 0));
    vt.push_back(mk(1,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_3500, 0));
    vt.push_back(mk(0,1, 0,0,           1,32'h6FFC,     0,0,            0, 0,0, 32'h0000_6FFC, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,0, 32'h0000_7000, 0));
    vt.push_back(mk(0,1, 0,0,           0,0,            0,0,            0, 0,1, 32'h0000_7004, 0));

    foreach (vt[i]) begin
      drive(vt[i].stall, vt[i].rdy, vt[i].br, vt[i].brt, vt[i].j, vt[i].jt,
            vt[i].eret, vt[i].epc, vt[i].exc);
      #1;
      check($sformatf("v%0d_flush", i), {31'd0, bus.f_flush}, {31'd0, vt[i].exp_flush});
      check($sformatf("v%0d_adel", i),  {31'd0, bus.f_adel},  {31'd0, vt[i].exp_adel});
      step();
      check($sformatf("v%0d_pc", i),    bus.f_pc, vt[i].exp_pc);
      check($sformatf("v%0d_pend", i),  {31'd0, bus.redirect_pending}, {31'd0, vt[i].exp_pend});
      check($sformatf("v%0d_valid", i), {31'd0, bus.f_valid}, 1);
    end

    // Mid-run asynchronous reset with a redirect buffered.
    drive(0, 0, 0, 0, 1, 32'h0000_3100, 0, 0, 0);
    step();
    check("pre_rst_pend", {31'd0, bus.redirect_pending}, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc",    bus.f_pc, RESET_VEC);
    check("async_rst_valid", {31'd0, bus.f_valid}, 0);
    check("async_rst_pend",  {31'd0, bus.redirect_pending}, 0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_pc0", bus.f_pc, RESET_VEC);
    check("post_rst_vld", {31'd0, bus.f_valid}, 1);
    step();
    check("post_rst_pc1", bus.f_pc, 32'h0000_3004);

    // Randomized traffic from a clean reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_pc = RESET_VEC;
    m_valid = 1'b0;
    m_pend.delete();
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) != 0);
      x  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 9) == 0);
      jj = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 7) == 0);
      bt  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2);
      jt2 = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2);
      ep  = 32'h3000 + ($urandom_range(0, 4095) << 2);
      drive(s, r, b, bt, jj, jt2, e, ep, x);
      #1;
      check("rnd_pc",    bus.f_pc, m_pc);
      check("rnd_valid", {31'd0, bus.f_valid}, {31'd0, m_valid});
      check("rnd_pend",  {31'd0, bus.redirect_pending}, {31'd0, (m_pend.size() != 0)});
      check("rnd_flush", {31'd0, bus.f_flush}, {31'd0, (x || (e && !s))});
      check("rnd_adel",  {31'd0, bus.f_adel}, {31'd0, model_adel()});
      model_update(s, r, b, bt, jj, jt2, e, ep, x);
      step();
    end
    check("rnd_final_pc", bus.f_pc, m_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
